ux607_i2c_master_seq: RTL and testbench

Transaction sequencer that sits directly upstream of the I2C master core's 8-bit register bus. It accepts one register-level request at a time: write one byte to a device register, or read one byte from it. It performs the full register-bus access sequence: program txr and cr, poll sr, check rxack/al, and fetch rxr. It returns a single response with data and a status code, so firmware-free agents (boot loaders, PMIC init) can use I2C without driving the byte-level command interface.

---
 rtl/ux607_i2c_master_seq_pkg.sv | 63 ++++++
 rtl/ux607_i2c_seq_wbm.sv | 64 ++++++
 rtl/ux607_i2c_master_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_ux607_i2c_master_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ux607_i2c_master_seq_pkg.sv
// Shared constants for the I2C register-level sequencer: register map, cr/sr bits,
// error codes, FSM states and the per-step byte selection helpers.
package ux607_i2c_master_seq_pkg;

  localparam logic [2:0] ADR_PRER_LO = 3'd0;
  localparam logic [2:0] ADR_PRER_HI = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXR_RXR = 3'd3;
  localparam logic [2:0] ADR_CR_SR   = 3'd4;

  localparam int CR_STA  = 7;
  localparam int CR_STO  = 6;
  localparam int CR_RD   = 5;
  localparam int CR_WR   = 4;
  localparam int CR_ACK  = 3;
  localparam int CR_IACK = 0;

  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [7:0] CTR_EN         = 8'h80;
  localparam logic [7:0] CR_START_WR    = (8'd1 << CR_STA) | (8'd1 << CR_WR) | (8'd1 << CR_IACK);
  localparam logic [7:0] CR_WRITE       = (8'd1 << CR_WR) | (8'd1 << CR_IACK);
  localparam logic [7:0] CR_WRITE_STOP  = (8'd1 << CR_STO) | (8'd1 << CR_WR) | (8'd1 << CR_IACK);
  localparam logic [7:0] CR_READ_NACK   = (8'd1 << CR_STO) | (8'd1 << CR_RD) | (8'd1 << CR_ACK) |
                                          (8'd1 << CR_IACK);
  localparam logic [7:0] CR_STOP        = (8'd1 << CR_STO) | (8'd1 << CR_IACK);

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_AL      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR, S_STOP, S_STOPWAIT, S_ABORT, S_RESP
  } state_e;

  // Byte placed in txr for a given step (step 3 of a read has no txr write).
  function automatic logic [7:0] txr_byte(input logic [1:0] step, input logic rd,
                                          input logic [6:0] dev, input logic [7:0] reg_addr,
                                          input logic [7:0] wdata);
    case (step)
      2'd0:    txr_byte = {dev, 1'b0};
      2'd1:    txr_byte = reg_addr;
      2'd2:    txr_byte = rd ? {dev, 1'b1} : wdata;
      default: txr_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] cr_byte(input logic [1:0] step, input logic rd);
    case (step)
      2'd0:    cr_byte = CR_START_WR;
      2'd1:    cr_byte = CR_WRITE;
      2'd2:    cr_byte = rd ? CR_START_WR : CR_WRITE_STOP;
      default: cr_byte = CR_READ_NACK;
    endcase
  endfunction

endpackage

// File: rtl/ux607_i2c_seq_wbm.sv
// Single-access register-bus engine: one go pulse yields one 3-cycle cyc/stb access
// against a slave with registered ack, with an enforced idle gap before the next one.
module ux607_i2c_seq_wbm (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       go_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic [7:0] rdata_q;

  // NOTE: state is updated with <= so every register samples pre-edge values;
  // a blocking = here would let later lines see this edge's new values.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (m_ack_i) begin
          cyc_q   <= 1'b0;
          done_q  <= 1'b1;
          rdata_q <= m_dat_i;
        end
      end else if (go_i && !done_q) begin
        // The cycle after done is the mandatory idle gap, so a toggling ack is never reused.
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
      end
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign m_we_o  = we_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;

endmodule

// File: rtl/ux607_i2c_master_seq.sv
// Register-level I2C transaction sequencer: turns one read/write request into the full
// txr/cr/sr/rxr access sequence on the I2C core's register bus and returns one response.
module ux607_i2c_master_seq
  import ux607_i2c_master_seq_pkg::*;
#(
  parameter logic [15:0] PRER_VAL   = 16'h0063,
  parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rd_i,
  input  logic [6:0] req_dev_i,
  input  logic [7:0] req_reg_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_err_o,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i,
  output logic       busy_o
);

  state_e      state_q;
  logic [1:0]  step_q;
  logic [15:0] poll_cnt_q;
  logic        go_q;
  logic        bus_we_q;
  logic [2:0]  bus_adr_q;
  logic [7:0]  bus_dat_q;
  logic        rd_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  err_e        rsp_err_q;

  logic        done;
  logic [7:0]  rdata;
  logic [15:0] poll_cnt_d;
  logic        poll_expired;

  assign poll_cnt_d   = poll_cnt_q + 16'd1;
  assign poll_expired = (poll_cnt_d == POLL_LIMIT);

  ux607_i2c_seq_wbm u_wbm (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .go_i     (go_q),
    .we_i     (bus_we_q),
    .adr_i    (bus_adr_q),
    .dat_i    (bus_dat_q),
    .done_o   (done),
    .rdata_o  (rdata),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  // Every transition into a bus state also issues that state's access (go_q pulse).
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= S_INIT;
      step_q      <= 2'd0;
      poll_cnt_q  <= 16'd0;
      go_q        <= 1'b1;
      bus_we_q    <= 1'b1;
      bus_adr_q   <= ADR_PRER_LO;
      bus_dat_q   <= PRER_VAL[7:0];
      rd_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= ERR_OK;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        S_INIT: if (done) begin
          if (step_q == 2'd2) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
          end else begin
            step_q    <= step_q + 2'd1;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_adr_q <= (step_q == 2'd0) ? ADR_PRER_HI : ADR_CTR;
            bus_dat_q <= (step_q == 2'd0) ? PRER_VAL[15:8] : CTR_EN;
          end
        end
        S_IDLE: if (req_valid_i) begin
          rd_q      <= req_rd_i;
          dev_q     <= req_dev_i;
          reg_q     <= req_reg_i;
          wdata_q   <= req_wdata_i;
          step_q    <= 2'd0;
          state_q   <= S_TXR;
          go_q      <= 1'b1;
          bus_we_q  <= 1'b1;
          bus_adr_q <= ADR_TXR_RXR;
          bus_dat_q <= {req_dev_i, 1'b0};
        end
        S_TXR: if (done) begin
          state_q   <= S_CR;
          go_q      <= 1'b1;
          bus_we_q  <= 1'b1;
          bus_adr_q <= ADR_CR_SR;
          bus_dat_q <= cr_byte(step_q, rd_q);
        end
        S_CR, S_STOP: if (done) begin
          state_q    <= (state_q == S_CR) ? S_POLL : S_STOPWAIT;
          poll_cnt_q <= 16'd0;
          go_q       <= 1'b1;
          bus_we_q   <= 1'b0;
          bus_adr_q  <= ADR_CR_SR;
        end
        S_POLL: if (done) begin
          if (rdata[SR_TIP]) begin
            if (poll_expired) begin
              state_q   <= S_ABORT;
              go_q      <= 1'b1;
              bus_we_q  <= 1'b1;
              bus_dat_q <= CR_STOP;
            end else begin
              poll_cnt_q <= poll_cnt_d;
              go_q       <= 1'b1;
            end
          end else if (rdata[SR_AL]) begin
            // The core has already released the bus, so no STOP is attempted.
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_AL;
            rsp_rdata_q <= 8'h00;
          end else if (rdata[SR_RXACK] && !(rd_q && step_q == 2'd3)) begin
            state_q   <= S_STOP;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_dat_q <= CR_STOP;
          end else if (!rd_q && step_q == 2'd2) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= 8'h00;
          end else if (rd_q && step_q == 2'd3) begin
            state_q   <= S_RXR;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b0;
            bus_adr_q <= ADR_TXR_RXR;
          end else if (rd_q && step_q == 2'd2) begin
            step_q    <= 2'd3;
            state_q   <= S_CR;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_dat_q <= CR_READ_NACK;
          end else begin
            step_q    <= step_q + 2'd1;
            state_q   <= S_TXR;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_adr_q <= ADR_TXR_RXR;
            bus_dat_q <= txr_byte(step_q + 2'd1, rd_q, dev_q, reg_q, wdata_q);
          end
        end
        S_STOPWAIT: if (done) begin
          if (!rdata[SR_BUSY]) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_NACK;
            rsp_rdata_q <= 8'h00;
          end else if (poll_expired) begin
            state_q   <= S_ABORT;
            go_q      <= 1'b1;
            bus_we_q  <= 1'b1;
            bus_dat_q <= CR_STOP;
          end else begin
            poll_cnt_q <= poll_cnt_d;
            go_q       <= 1'b1;
          end
        end
        S_RXR: if (done) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= ERR_OK;
          rsp_rdata_q <= rdata;
        end
        S_ABORT: if (done) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= ERR_TIMEOUT;
          rsp_rdata_q <= 8'h00;
        end
        S_RESP: if (rsp_ready_i) begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= ERR_OK;
          rsp_rdata_q <= 8'h00;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ux607_i2c_master_seq.sv
// Directed bench: an I2C-core register model answers the bus; expected accesses and
// responses are queued at stimulus time and compared as the DUT produces them.
module tb_ux607_i2c_master_seq;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } acc_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic [1:0] err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       req_valid = 1'b0, req_rd = 1'b0, rsp_ready = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, busy;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_cyc, m_stb, m_we, s_ack;
  logic [2:0] m_adr;
  logic [7:0] m_dat_o, m_dat_i, sr_val;

  // Slave model state (written only by the monitor) and scenario knobs (written by the stimulus).
  acc_t obs_mem [0:1023];
  int   obs_wr = 0, cr_cnt = 0, sr_rd = 0;
  int   nack_at = -1, al_at = -1;
  bit   stuck_tip = 1'b0;
  logic [7:0] rxr_val = 8'h3C;

  acc_t exp_q[$];
  rsp_t rsp_q[$];
  int   chk_idx = 0;
  int   n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  ux607_i2c_master_seq #(.PRER_VAL(16'h0063), .POLL_LIMIT(16'd8)) dut (
    .wb_clk_i (clk),       .arst_i (arst_n),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_rd_i (req_rd),
    .req_dev_i (req_dev),  .req_reg_i (req_reg),   .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata), .rsp_err_o (rsp_err),
    .m_cyc_o (m_cyc), .m_stb_o (m_stb), .m_we_o (m_we), .m_adr_o (m_adr),
    .m_dat_o (m_dat_o), .m_dat_i (m_dat_i), .m_ack_i (s_ack), .busy_o (busy)
  );

  always @(posedge clk or negedge arst_n)
    if (!arst_n) s_ack <= 1'b0;
    else         s_ack <= m_cyc & m_stb & ~s_ack;

  assign sr_val = {(cr_cnt == nack_at), (sr_rd == 1), (cr_cnt == al_at), 3'b000,
                   (stuck_tip || sr_rd == 1), 1'b0};
  assign m_dat_i = (m_adr == 3'd3) ? rxr_val : (m_adr == 3'd4) ? sr_val : 8'h00;

  always @(negedge clk) begin
    if (arst_n && m_cyc && m_stb && !s_ack && obs_wr < 1024) begin
      obs_mem[obs_wr] <= '{m_we, m_adr, (m_we ? m_dat_o : 8'h00)};
      obs_wr <= obs_wr + 1;
      if (m_adr == 3'd4) begin
        if (m_we) begin
          cr_cnt <= cr_cnt + 1;
          sr_rd  <= 0;
        end else begin
          sr_rd <= sr_rd + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    exp_q.push_back('{we, adr, dat});
  endtask

  task automatic push_wait(input logic [7:0] cr);
    push(1'b1, 3'd4, cr);
    push(1'b0, 3'd4, 8'h00);
    push(1'b0, 3'd4, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] txr, input logic [7:0] cr);
    push(1'b1, 3'd3, txr);
    push_wait(cr);
  endtask

  task automatic compare_observed(input string tag);
    acc_t e;
    while (chk_idx < obs_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s access %0d", tag, chk_idx), 32'(obs_mem[chk_idx]), 32'(e));
      chk_idx++;
    end
  endtask

  task automatic check_bus(input string tag);
    repeat (3) @(negedge clk);
    compare_observed(tag);
    check({tag, " missing accesses"}, exp_q.size(), 0);
    check({tag, " extra accesses"}, obs_wr, chk_idx);
    exp_q.delete();
    chk_idx = obs_wr;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1);
  endtask

  task automatic start_req(input string tag, input logic rd, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    req_rd = rd; req_dev = dev; req_reg = ra; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " ready drop"}, req_ready, 0);
    check({tag, " no strobe at accept"}, m_cyc, 0);
    @(negedge clk);
    check({tag, " first strobe"}, m_cyc, 1);
  endtask

  task automatic run_req(input string tag, input logic rd, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input logic [7:0] exp_rdata, input logic [1:0] exp_err, input bit early);
    rsp_t e;
    wait_ready(tag);
    rsp_q.push_back('{exp_rdata, exp_err});
    start_req(tag, rd, dev, ra, wd);
    if (early) rsp_ready = 1'b1;
    for (int i = 0; i < 600 && !rsp_valid; i++) @(negedge clk);
    check({tag, " rsp_valid"}, rsp_valid, 1);
    e = rsp_q.pop_front();
    check({tag, " rdata"}, rsp_rdata, e.rdata);
    check({tag, " err"}, rsp_err, e.err);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, rsp_valid, 0);
    check({tag, " ready after rsp"}, req_ready, 1);
    check_bus(tag);
  endtask

  task automatic push_init();
    push(1'b1, 3'd0, 8'h63);
    push(1'b1, 3'd1, 8'h00);
    push(1'b1, 3'd2, 8'h80);
  endtask

  initial begin
    int   base;
    logic saw_valid;

    #3;
    check("reset req_ready", req_ready, 0);
    check("reset busy", busy, 1);
    check("reset outputs", {rsp_valid, rsp_rdata, rsp_err, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 0);

    push_init();
    @(negedge clk);
    arst_n = 1'b1;
    wait_ready("init");
    check("idle busy", busy, 0);
    check_bus("init");

    push_byte(8'hA0, 8'h91); push_byte(8'h10, 8'h11); push_byte(8'hA5, 8'h51);
    run_req("write", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 2'b00, 1'b0);

    push_byte(8'hA0, 8'h91); push_byte(8'h02, 8'h11); push_byte(8'hA1, 8'h91);
    push_wait(8'h69); push(1'b0, 3'd3, 8'h00);
    run_req("read", 1'b1, 7'h50, 8'h02, 8'h00, 8'h3C, 2'b00, 1'b1);

    rxr_val = 8'hC3;
    push_byte(8'hA0, 8'h91); push_byte(8'h7F, 8'h11); push_byte(8'hA1, 8'h91);
    push_wait(8'h69); push(1'b0, 3'd3, 8'h00);
    run_req("read2", 1'b1, 7'h50, 8'h7F, 8'h00, 8'hC3, 2'b00, 1'b0);

    nack_at = cr_cnt + 1;
    push_byte(8'hA0, 8'h91); push_wait(8'h41);
    run_req("nack", 1'b1, 7'h50, 8'h02, 8'h00, 8'h00, 2'b01, 1'b0);
    nack_at = -1;

    al_at = cr_cnt + 2;
    push_byte(8'hA0, 8'h91); push_byte(8'h10, 8'h11);
    run_req("arb", 1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 2'b10, 1'b0);
    al_at = -1;

    stuck_tip = 1'b1;
    push(1'b1, 3'd3, 8'hA0); push(1'b1, 3'd4, 8'h91);
    repeat (8) push(1'b0, 3'd4, 8'h00);
    push(1'b1, 3'd4, 8'h41);
    run_req("timeout", 1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 2'b11, 1'b0);
    stuck_tip = 1'b0;

    // Reset in the middle of a read: the partial sequence must match, then INIT reruns.
    wait_ready("abort");
    push_byte(8'hA0, 8'h91); push_byte(8'h02, 8'h11); push_byte(8'hA1, 8'h91);
    base = obs_wr;
    start_req("abort", 1'b1, 7'h50, 8'h02, 8'h00);
    for (int i = 0; i < 300 && obs_wr < base + 6; i++) @(negedge clk);
    check("abort progress", obs_wr >= base + 6, 1);
    #2 arst_n = 1'b0;
    #1;
    check("abort rsp/bus outputs", {rsp_valid, rsp_rdata, rsp_err, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 0);
    check("abort req_ready", req_ready, 0);
    check("abort busy", busy, 1);
    compare_observed("abort prefix");
    exp_q.delete();
    chk_idx = obs_wr;
    push_init();
    @(negedge clk);
    arst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 300 && !req_ready; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | rsp_valid;
    end
    check("reinit ready", req_ready, 1);
    check("reinit no rsp", saw_valid, 0);
    check_bus("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
